// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order FIFO of word stores between the MEM stage and data
// memory. Illegal stores are rejected at entry, and loads forward data from the
// youngest matching entry that is still buffered.
module dm_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3,
    parameter logic [31:0] DM_TOP = 32'h0000_2fff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [31:0]      st_pc,
    output logic             st_err,
    output logic [31:0]      st_err_pc,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    input  logic             drain_en,
    output logic             dm_wr,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wd,
    output logic [31:0]      dm_pc,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = CNT_W - 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic legal;
    logic push;
    logic reject;
    logic pop;

    // Byte-offset bits of a load address do not take part in the word match.
    logic ld_addr_unused;
    assign ld_addr_unused = ^ld_addr[1:0];

    // Handshake, legality and drain decisions; status comes from the registered count.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        st_ready = !full;
        legal    = (st_addr[1:0] == 2'b00) && (st_addr <= DM_TOP);
        push     = st_valid && st_ready && legal;
        reject   = st_valid && st_ready && !legal;
        pop      = !empty && drain_en;
        dm_wr    = pop;
        dm_addr  = {addr_q[head], 2'b00};
        dm_wd    = data_q[head];
        dm_pc    = pc_q[head];
    end

    // Pointers, valid bits, occupancy and the error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            valid_q   <= '0;
            count     <= '0;
            st_err    <= 1'b0;
            st_err_pc <= '0;
        end else begin
            st_err <= reject;
            if (reject) begin
                st_err_pc <= st_pc;
            end
            if (push) begin
                tail          <= tail + PTR_W'(1);
                valid_q[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + PTR_W'(1);
                valid_q[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload; meaningful only where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr[31:2];
            data_q[tail] <= st_data;
            pc_q[tail]   <= st_pc;
        end
    end

    // Forwarding: walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: reset, ordered drain, full/stall,
// forwarding, store rejection, reset during drain and pointer wrap-around.
module tb_dm_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_err;
    logic [31:0] st_err_pc;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_en;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int errors = 0;
    int checks = 0;

    logic [63:0] wr_q  [$];
    logic [63:0] exp_q [$];

    dm_store_buffer #(.DEPTH(4), .CNT_W(3), .DM_TOP(32'h0000_2fff)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_pc(st_pc), .st_err(st_err), .st_err_pc(st_err_pc),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .drain_en(drain_en), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_pc(dm_pc), .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write that data memory captures.
    always @(posedge clk) begin
        if (reset && dm_wr) wr_q.push_back({dm_addr, dm_wd});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_writes(input string name);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (wr_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_wr%0d: got %h expected %h", name, i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
        ld_addr = 32'h0; drain_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", st_ready); end
        checks++; if (dm_wr !== 1'b0) begin errors++; $display("FAIL rst_dm_wr: got %b expected 0", dm_wr); end
        checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL rst_st_err: got %b expected 0", st_err); end
        checks++; if (st_err_pc !== 32'h0) begin errors++; $display("FAIL rst_err_pc: got %h expected 0", st_err_pc); end
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL rst_ld_hit: got %b expected 0", ld_hit); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_in_order();
        drain_en = 1'b1;
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h11; st_pc = 32'h100;
        @(negedge clk);
        checks++; if (dm_wr !== 1'b0) begin errors++; $display("FAIL ord_idle_wr: got %b expected 0", dm_wr); end
        step();
        st_addr = 32'h14; st_data = 32'h22; st_pc = 32'h104;
        @(negedge clk);
        checks++; if (dm_wr !== 1'b1) begin errors++; $display("FAIL ord_wr1: got %b expected 1", dm_wr); end
        checks++; if (dm_addr !== 32'h10) begin errors++; $display("FAIL ord_addr1: got %h expected 10", dm_addr); end
        checks++; if (dm_wd !== 32'h11) begin errors++; $display("FAIL ord_wd1: got %h expected 11", dm_wd); end
        checks++; if (dm_pc !== 32'h100) begin errors++; $display("FAIL ord_pc1: got %h expected 100", dm_pc); end
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (dm_wr !== 1'b1) begin errors++; $display("FAIL ord_wr2: got %b expected 1", dm_wr); end
        checks++; if (dm_addr !== 32'h14) begin errors++; $display("FAIL ord_addr2: got %h expected 14", dm_addr); end
        checks++; if (dm_wd !== 32'h22) begin errors++; $display("FAIL ord_wd2: got %h expected 22", dm_wd); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL ord_count: got %0d expected 1", count); end
        step();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ord_empty: got %b expected 1", empty); end
        step();
    endtask

    task automatic test_full();
        wr_q.delete(); exp_q.delete();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'h100 + 32'(i); st_pc = 32'h200;
            exp_q.push_back({st_addr, st_data});
            step();
        end
        st_addr = 32'h80; st_data = 32'h999;
        @(negedge clk);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_full: got %b expected 1", full); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", st_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_5th_count: got %0d expected 4", count); end
        checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL full_5th_err: got %b expected 0", st_err); end
        drain_en = 1'b1;
        repeat (4) step();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b expected 1", empty); end
        compare_writes("full");
        step();
    endtask

    task automatic test_forward();
        wr_q.delete();
        drain_en = 1'b0;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hAAAA; st_pc = 32'h300; ld_addr = 32'h20;
        @(negedge clk);
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle: got %b expected 0", ld_hit); end
        step();
        st_data = 32'hBBBB;
        @(negedge clk);
        checks++; if (ld_data !== 32'hAAAA) begin errors++; $display("FAIL fwd_one: got %h expected AAAA", ld_data); end
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit20: got %b expected 1", ld_hit); end
        checks++; if (ld_data !== 32'hBBBB) begin errors++; $display("FAIL fwd_data20: got %h expected BBBB", ld_data); end
        ld_addr = 32'h22; #1;
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit22: got %b expected 1", ld_hit); end
        checks++; if (ld_data !== 32'hBBBB) begin errors++; $display("FAIL fwd_data22: got %h expected BBBB", ld_data); end
        ld_addr = 32'h24; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_hit24: got %b expected 0", ld_hit); end
        checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL fwd_data24: got %h expected 0", ld_data); end
        ld_addr = 32'h20; drain_en = 1'b1;
        step();
        @(negedge clk);
        checks++; if (!(dm_wr === 1'b1 && ld_hit === 1'b1 && ld_data === 32'hBBBB)) begin
            errors++; $display("FAIL fwd_head_pop: got wr=%b hit=%b data=%h expected 1 1 BBBB", dm_wr, ld_hit, ld_data);
        end
        step();
        @(negedge clk);
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL fwd_after_drain: got %b expected 0", ld_hit); end
        exp_q.delete();
        exp_q.push_back({32'h20, 32'hAAAA});
        exp_q.push_back({32'h20, 32'hBBBB});
        compare_writes("fwd");
        step();
    endtask

    task automatic test_err();
        drain_en = 1'b0;
        st_valid = 1'b1; st_addr = 32'h13; st_data = 32'h5; st_pc = 32'h3010;
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (st_err !== 1'b1) begin errors++; $display("FAIL err_mis_pulse: got %b expected 1", st_err); end
        checks++; if (st_err_pc !== 32'h3010) begin errors++; $display("FAIL err_mis_pc: got %h expected 3010", st_err_pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL err_mis_count: got %0d expected 0", count); end
        step();
        @(negedge clk);
        checks++; if (st_err !== 1'b0) begin errors++; $display("FAIL err_mis_end: got %b expected 0", st_err); end
        checks++; if (st_err_pc !== 32'h3010) begin errors++; $display("FAIL err_pc_hold: got %h expected 3010", st_err_pc); end
        st_valid = 1'b1; st_addr = 32'h3000; st_pc = 32'h3020;
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (!(st_err === 1'b1 && st_err_pc === 32'h3020 && count === 3'd0)) begin
            errors++; $display("FAIL err_range: got err=%b pc=%h cnt=%0d expected 1 3020 0", st_err, st_err_pc, count);
        end
        step();
        st_valid = 1'b1; st_addr = 32'h2ffc; st_pc = 32'h3030;
        step();
        st_valid = 1'b0;
        @(negedge clk);
        checks++; if (!(st_err === 1'b0 && count === 3'd1 && st_err_pc === 32'h3020)) begin
            errors++; $display("FAIL err_top_legal: got err=%b cnt=%0d pc=%h expected 0 1 3020", st_err, count, st_err_pc);
        end
        drain_en = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset_mid_drain();
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h60 + 32'(4 * i); st_data = 32'h70 + 32'(i); st_pc = 32'h400;
            step();
        end
        st_valid = 1'b0; drain_en = 1'b1; ld_addr = 32'h64;
        @(negedge clk);
        checks++; if (!(dm_wr === 1'b1 && count === 3'd3)) begin
            errors++; $display("FAIL mrst_pre: got wr=%b cnt=%0d expected 1 3", dm_wr, count);
        end
        #1 reset = 1'b0;
        #1;
        checks++; if (!(count === 3'd0 && empty === 1'b1 && dm_wr === 1'b0 && ld_hit === 1'b0 && st_ready === 1'b1)) begin
            errors++; $display("FAIL mrst_state: got cnt=%0d empty=%b wr=%b hit=%b rdy=%b expected 0 1 0 0 1",
                               count, empty, dm_wr, ld_hit, st_ready);
        end
        repeat (2) @(negedge clk);
        wr_q.delete();
        reset = 1'b1;
        repeat (4) step();
        @(negedge clk);
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL mrst_no_writes: got %0d expected 0", wr_q.size()); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b expected 1", empty); end
        step();
    endtask

    task automatic test_back_to_back();
        int k;
        int mc;
        bit acc;
        wr_q.delete(); exp_q.delete();
        drain_en = 1'b0; k = 0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * k); st_data = 32'hD000 + 32'(k); st_pc = 32'h500 + 32'(k);
            exp_q.push_back({st_addr, st_data});
            k++;
            step();
        end
        drain_en = 1'b1; mc = 4;
        for (int c = 0; c < 20; c++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * k); st_data = 32'hD000 + 32'(k); st_pc = 32'h500 + 32'(k);
            @(negedge clk);
            acc = (mc < 4);
            checks++; if (st_ready !== acc) begin errors++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, st_ready, acc); end
            if (acc) exp_q.push_back({st_addr, st_data});
            mc = mc + int'(acc) - ((mc > 0) ? 1 : 0);
            step();
            if (acc) k++;
        end
        st_valid = 1'b0;
        for (int w = 0; w < 12 && !empty; w++) step();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drain_timeout: got empty=%b expected 1", empty); end
        checks++; if (exp_q.size() != 23) begin errors++; $display("FAIL b2b_accepted: got %0d expected 23", exp_q.size()); end
        compare_writes("b2b");
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_forward();
        test_err();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
